atencion_solicitudes: RTL and testbench

- Servicing side of the floor-request path: consumes pending requests held by the request registrar, moves the car, opens the door, and emits one-cycle clear pulses for served floors.
- Top level updates pending state as next = (botones | pending) & ~atendidos.
- Collective scan policy: the car keeps its direction while requests remain ahead.

---
 rtl/atencion_solicitudes.sv | 255 +++++++++++++++++++++++++
 tb/tb_atencion_solicitudes.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/atencion_solicitudes.sv
// Servicing side of the floor-request path: collective-scan car controller.
// Latency: 1 cycle from a pending request in REPOSO to the move/door decision; one floor = T_VIAJE cycles.
// Backpressure: none; requests stay pending upstream until the one-cycle atendidos pulse clears them.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   solicitudes    pending requests, bit i = floor i (held by the request registrar)
//   parada         emergency stop, present only with ASCENSOR_PARADA_EMERGENCIA_EN defined
//   atendidos      registered one-hot clear pulse for the floor being served
//   piso_actual    current floor 0..N_PISOS-1
//   subiendo       car moving up
//   bajando        car moving down
//   puerta_abierta door open
//   ocupado        any state other than REPOSO
//
// Optional feature macro: ASCENSOR_PARADA_EMERGENCIA_EN (adds the parada freeze input).

module atencion_solicitudes #(
    parameter int N_PISOS  = 10,
    parameter int T_VIAJE  = 8,
    parameter int T_PUERTA = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_PISOS-1:0] solicitudes,
`ifdef ASCENSOR_PARADA_EMERGENCIA_EN
    input  logic               parada,
`endif
    output logic [N_PISOS-1:0] atendidos,
    output logic [3:0]         piso_actual,
    output logic               subiendo,
    output logic               bajando,
    output logic               puerta_abierta,
    output logic               ocupado
);

    // One timer serves both travel and door phases, so it is sized for the longer one.
    localparam int T_MAX = (T_VIAJE > T_PUERTA) ? T_VIAJE : T_PUERTA;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TW-1:0] FIN_VIAJE  = TW'(T_VIAJE - 1);
    localparam logic [TW-1:0] FIN_PUERTA = TW'(T_PUERTA - 1);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        SUBIR  = 2'd1,
        BAJAR  = 2'd2,
        PUERTA = 2'd3
    } estado_t;

    // ------------------------------------------------------------------
    // Floor masks
    // ------------------------------------------------------------------
    function automatic logic [N_PISOS-1:0] mascara_arriba(input logic [3:0] p);
        logic [N_PISOS-1:0] m;
        m = '0;
        for (int i = 0; i < N_PISOS; i++) begin
            m[i] = (i > int'(p));
        end
        return m;
    endfunction

    function automatic logic [N_PISOS-1:0] mascara_abajo(input logic [3:0] p);
        logic [N_PISOS-1:0] m;
        m = '0;
        for (int i = 0; i < N_PISOS; i++) begin
            m[i] = (i < int'(p));
        end
        return m;
    endfunction

    // Out-of-range floors give an all-zero vector, so a wrapped floor index is harmless.
    function automatic logic [N_PISOS-1:0] uno_caliente(input logic [3:0] p);
        logic [N_PISOS-1:0] m;
        m = '0;
        for (int i = 0; i < N_PISOS; i++) begin
            m[i] = (i == int'(p));
        end
        return m;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    estado_t            estado_q,         estado_d;
    logic [3:0]         piso_q,           piso_d;
    logic               dir_q,            dir_d;     // 1 = up, 0 = down
    logic [TW-1:0]      timer_q,          timer_d;
    logic [N_PISOS-1:0] atendidos_q,      atendidos_d;
    logic               subiendo_q,       subiendo_d;
    logic               bajando_q,        bajando_d;
    logic               puerta_abierta_q, puerta_abierta_d;
    logic               ocupado_q,        ocupado_d;

    // ------------------------------------------------------------------
    // Request views relative to the current floor and to the floor the
    // car reaches at the end of the current travel interval.
    // ------------------------------------------------------------------
    logic [3:0] piso_sube;
    logic [3:0] piso_baja;
    logic       aqui;
    logic       hay_arriba;
    logic       hay_abajo;
    logic       aqui_sube;
    logic       arriba_sube;
    logic       aqui_baja;
    logic       abajo_baja;

    assign piso_sube   = piso_q + 4'd1;
    assign piso_baja   = piso_q - 4'd1;

    assign aqui        = |(solicitudes & uno_caliente(piso_q));
    assign hay_arriba  = |(solicitudes & mascara_arriba(piso_q));
    assign hay_abajo   = |(solicitudes & mascara_abajo(piso_q));

    assign aqui_sube   = |(solicitudes & uno_caliente(piso_sube));
    assign arriba_sube = |(solicitudes & mascara_arriba(piso_sube));
    assign aqui_baja   = |(solicitudes & uno_caliente(piso_baja));
    assign abajo_baja  = |(solicitudes & mascara_abajo(piso_baja));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        estado_d    = estado_q;
        piso_d      = piso_q;
        dir_d       = dir_q;
        timer_d     = timer_q;
        atendidos_d = '0;

        unique case (estado_q)
            REPOSO: begin
                timer_d = '0;
                if (aqui) begin
                    estado_d    = PUERTA;
                    atendidos_d = uno_caliente(piso_q);
                end else if (hay_arriba && hay_abajo) begin
                    // Requests on both sides: keep the last direction of travel.
                    estado_d = dir_q ? SUBIR : BAJAR;
                end else if (hay_arriba) begin
                    estado_d = SUBIR;
                    dir_d    = 1'b1;
                end else if (hay_abajo) begin
                    estado_d = BAJAR;
                    dir_d    = 1'b0;
                end
            end

            SUBIR: begin
                if (timer_q == FIN_VIAJE) begin
                    // Floor changes on this edge; the decision uses the new floor.
                    piso_d  = piso_sube;
                    timer_d = '0;
                    if (aqui_sube) begin
                        estado_d    = PUERTA;
                        atendidos_d = uno_caliente(piso_sube);
                    end else if (!arriba_sube) begin
                        estado_d = REPOSO;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            BAJAR: begin
                if (timer_q == FIN_VIAJE) begin
                    piso_d  = piso_baja;
                    timer_d = '0;
                    if (aqui_baja) begin
                        estado_d    = PUERTA;
                        atendidos_d = uno_caliente(piso_baja);
                    end else if (!abajo_baja) begin
                        estado_d = REPOSO;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            PUERTA: begin
                // During the pulse cycle the registrar has not yet cleared the
                // request, so aqui is only a fresh press when no pulse is out.
                if (aqui && (atendidos_q == '0)) begin
                    atendidos_d = uno_caliente(piso_q);
                    timer_d     = '0;
                end else if (timer_q == FIN_PUERTA) begin
                    estado_d = REPOSO;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                estado_d = REPOSO;
                timer_d  = '0;
            end
        endcase

`ifdef ASCENSOR_PARADA_EMERGENCIA_EN
        // Emergency stop freezes everything in place; no floor is served meanwhile.
        if (parada) begin
            estado_d    = estado_q;
            piso_d      = piso_q;
            dir_d       = dir_q;
            timer_d     = timer_q;
            atendidos_d = '0;
        end
`endif
    end

    // Status flags are registered from the next state so they line up with estado_q.
    always_comb begin
        subiendo_d       = (estado_d == SUBIR);
        bajando_d        = (estado_d == BAJAR);
        puerta_abierta_d = (estado_d == PUERTA);
        ocupado_d        = (estado_d != REPOSO);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q         <= REPOSO;
            piso_q           <= '0;
            dir_q            <= 1'b1;
            timer_q          <= '0;
            atendidos_q      <= '0;
            subiendo_q       <= 1'b0;
            bajando_q        <= 1'b0;
            puerta_abierta_q <= 1'b0;
            ocupado_q        <= 1'b0;
        end else begin
            estado_q         <= estado_d;
            piso_q           <= piso_d;
            dir_q            <= dir_d;
            timer_q          <= timer_d;
            atendidos_q      <= atendidos_d;
            subiendo_q       <= subiendo_d;
            bajando_q        <= bajando_d;
            puerta_abierta_q <= puerta_abierta_d;
            ocupado_q        <= ocupado_d;
        end
    end

    assign atendidos      = atendidos_q;
    assign piso_actual    = piso_q;
    assign subiendo       = subiendo_q;
    assign bajando        = bajando_q;
    assign puerta_abierta = puerta_abierta_q;
    assign ocupado        = ocupado_q;

endmodule

// File: tb/tb_atencion_solicitudes.sv
// Bench for atencion_solicitudes with T_VIAJE=4, T_PUERTA=6, N_PISOS=10.
// A small registrar model turns button presses into the pending vector,
// clearing a floor when the DUT pulses atendidos for it.

module tb_atencion_solicitudes;

    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn = '0;
    logic [N-1:0] pend;
    logic [N-1:0] atendidos;
    logic [3:0]   piso_actual;
    logic         subiendo;
    logic         bajando;
    logic         puerta_abierta;
    logic         ocupado;
`ifdef ASCENSOR_PARADA_EMERGENCIA_EN
    logic         parada = 1'b0;
`endif

    always #5 clk = ~clk;

    atencion_solicitudes #(
        .N_PISOS (10),
        .T_VIAJE (4),
        .T_PUERTA(6)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .solicitudes   (pend),
`ifdef ASCENSOR_PARADA_EMERGENCIA_EN
        .parada        (parada),
`endif
        .atendidos     (atendidos),
        .piso_actual   (piso_actual),
        .subiendo      (subiendo),
        .bajando       (bajando),
        .puerta_abierta(puerta_abierta),
        .ocupado       (ocupado)
    );

    // Request registrar: next = (botones | pending) & ~atendidos
    always_ff @(posedge clk) begin
        if (!rst_n) pend <= '0;
        else        pend <= (btn | pend) & ~atendidos;
    end

    typedef struct {
        logic         rst_n;
        logic [N-1:0] btn;    // applied for the first cycle only
        int           ciclos; // clock edges before the check
        logic [3:0]   piso;
        logic         sub;
        logic         baj;
        logic         pta;
        logic         ocu;
        logic [N-1:0] aten;
    } vec_t;

    vec_t tabla[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic agrega(input logic r, input logic [N-1:0] b, input int c,
                          input logic [3:0] p, input logic s, input logic bj,
                          input logic pt, input logic oc, input logic [N-1:0] a);
        vec_t v;
        v.rst_n = r; v.btn = b; v.ciclos = c;
        v.piso = p; v.sub = s; v.baj = bj; v.pta = pt; v.ocu = oc; v.aten = a;
        tabla.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compara(input string nombre, input logic [17:0] req);
        logic [17:0] act;
        act = {piso_actual, subiendo, bajando, puerta_abierta, ocupado, atendidos};
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got piso=%0d sub=%b baj=%b pta=%b ocu=%b aten=%03h, expected piso=%0d sub=%b baj=%b pta=%b ocu=%b aten=%03h",
                     nombre, act[17:14], act[13], act[12], act[11], act[10], act[9:0],
                     req[17:14], req[13], req[12], req[11], req[10], req[9:0]);
        end
    endtask

    initial begin
        logic [17:0] req;

        //       rst btn    cyc piso sub baj pta ocu aten
        // Reset
        agrega(0, 10'h000, 2, 0, 0, 0, 0, 0, 10'h000);   // 0
        // Floor 0 -> 3
        agrega(1, 10'h008, 1, 0, 0, 0, 0, 0, 10'h000);   // 1 request latched, no decision yet
        agrega(1, 10'h000, 1, 0, 1, 0, 0, 1, 10'h000);   // 2 SUBIR after 1 cycle
        agrega(1, 10'h000, 3, 0, 1, 0, 0, 1, 10'h000);   // 3 still floor 0 after 3 cycles
        agrega(1, 10'h000, 1, 1, 1, 0, 0, 1, 10'h000);   // 4 floor 1 after 4
        agrega(1, 10'h000, 4, 2, 1, 0, 0, 1, 10'h000);   // 5 floor 2 after 8
        agrega(1, 10'h000, 3, 2, 1, 0, 0, 1, 10'h000);   // 6
        agrega(1, 10'h000, 1, 3, 0, 0, 1, 1, 10'h008);   // 7 floor 3 after 12, door + pulse
        agrega(1, 10'h000, 1, 3, 0, 0, 1, 1, 10'h000);   // 8 pulse is one cycle
        agrega(1, 10'h000, 4, 3, 0, 0, 1, 1, 10'h000);   // 9 door cycle 6
        agrega(1, 10'h000, 1, 3, 0, 0, 0, 0, 10'h000);   // 10 REPOSO
        // Request at current floor
        agrega(0, 10'h000, 2, 0, 0, 0, 0, 0, 10'h000);   // 11 reset from idle at 3
        agrega(1, 10'h001, 2, 0, 0, 0, 1, 1, 10'h001);   // 12 door next cycle
        agrega(1, 10'h000, 5, 0, 0, 0, 1, 1, 10'h000);   // 13
        agrega(1, 10'h000, 1, 0, 0, 0, 0, 0, 10'h000);   // 14
        // Collective scan up with late requests 5 and 1
        agrega(1, 10'h084, 2, 0, 1, 0, 0, 1, 10'h000);   // 15
        agrega(1, 10'h000, 8, 2, 0, 0, 1, 1, 10'h004);   // 16 serve 2
        agrega(1, 10'h000, 7, 2, 1, 0, 0, 1, 10'h000);   // 17 rising from 2 toward 7
        agrega(1, 10'h022, 1, 2, 1, 0, 0, 1, 10'h000);   // 18 add 5 and 1
        agrega(1, 10'h000, 11, 5, 0, 0, 1, 1, 10'h020);  // 19 stop at 5
        agrega(1, 10'h000, 7, 5, 1, 0, 0, 1, 10'h000);   // 20 both sides, keep up
        agrega(1, 10'h000, 8, 7, 0, 0, 1, 1, 10'h080);   // 21 stop at 7
        agrega(1, 10'h000, 7, 7, 0, 1, 0, 1, 10'h000);   // 22 reverse
        agrega(1, 10'h000, 12, 4, 0, 1, 0, 1, 10'h000);  // 23
        agrega(1, 10'h000, 12, 1, 0, 0, 1, 1, 10'h002);  // 24 serve 1
        agrega(1, 10'h000, 6, 1, 0, 0, 0, 0, 10'h000);   // 25
        // Set up idle at 4 with last move down, then 0x044
        agrega(1, 10'h020, 2, 1, 1, 0, 0, 1, 10'h000);   // 26
        agrega(1, 10'h000, 16, 5, 0, 0, 1, 1, 10'h020);  // 27
        agrega(1, 10'h000, 6, 5, 0, 0, 0, 0, 10'h000);   // 28
        agrega(1, 10'h010, 2, 5, 0, 1, 0, 1, 10'h000);   // 29
        agrega(1, 10'h000, 4, 4, 0, 0, 1, 1, 10'h010);   // 30
        agrega(1, 10'h000, 6, 4, 0, 0, 0, 0, 10'h000);   // 31 idle at 4, dir down
        agrega(1, 10'h044, 2, 4, 0, 1, 0, 1, 10'h000);   // 32 stored dir wins: down
        agrega(1, 10'h000, 8, 2, 0, 0, 1, 1, 10'h004);   // 33 serve 2
        agrega(1, 10'h000, 7, 2, 1, 0, 0, 1, 10'h000);   // 34 then up
        agrega(1, 10'h000, 16, 6, 0, 0, 1, 1, 10'h040);  // 35 serve 6
        agrega(1, 10'h000, 6, 6, 0, 0, 0, 0, 10'h000);   // 36
        // Reset mid-SUBIR at timer=2
        agrega(1, 10'h100, 4, 6, 1, 0, 0, 1, 10'h000);   // 37
        agrega(0, 10'h000, 1, 0, 0, 0, 0, 0, 10'h000);   // 38 REPOSO at floor 0 next cycle
        agrega(0, 10'h000, 1, 0, 0, 0, 0, 0, 10'h000);   // 39

        for (int k = 0; k < tabla.size(); k++) begin
            rst_n = tabla[k].rst_n;
            btn   = tabla[k].btn;
            tick();
            btn = '0;
            for (int c = 1; c < tabla[k].ciclos; c++) tick();
            req = {tabla[k].piso, tabla[k].sub, tabla[k].baj, tabla[k].pta,
                   tabla[k].ocu, tabla[k].aten};
            compara($sformatf("vec%0d", k), req);
        end

        // Button held 3 cycles during the door: second pulse, door closes 6 cycles later.
        rst_n = 1'b1;
        btn   = 10'h001;
        tick();
        btn = '0;
        tick();
        compara("puerta_ini", {4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h001});
        for (int k = 3; k <= 12; k++) begin
            logic       abierta;
            logic [N-1:0] pulso;
            btn     = (k >= 5 && k <= 7) ? 10'h001 : 10'h000;
            tick();
            abierta = (k <= 11);
            pulso   = (k == 6) ? 10'h001 : 10'h000;
            compara($sformatf("reten_e%0d", k), {4'd0, 1'b0, 1'b0, abierta, abierta, pulso});
        end
        btn = '0;

`ifdef ASCENSOR_PARADA_EMERGENCIA_EN
        // Emergency stop for 5 cycles mid-SUBIR delays arrival by exactly 5 cycles.
        btn = 10'h002;
        tick();
        btn = '0;
        tick();
        compara("parada_sube", {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h000});
        tick();
        parada = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        compara("parada_congelado", {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h000});
        parada = 1'b0;
        tick();
        tick();
        compara("parada_antes", {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h000});
        tick();
        compara("parada_llega", {4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 10'h002});
        for (int c = 0; c < 6; c++) tick();
        compara("parada_fin", {4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
